// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [4:0]  REG_X0   = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous active-high reset
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count increment requests, holding at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic             e_valid,
    input  logic [4:0]       e_rd,
    input  logic             e_is_load,
    input  logic             e_jb,
    input  logic             e_mdu_start,
    input  logic             mdu_done,
    input  logic             m_mem_req,
    input  logic             m_mem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             mdu_go,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    mdu_state_t state;

    logic freeze;
    logic load_use;
    logic mdu_issue;
    logic mdu_hold;

    assign freeze   = m_mem_req & ~m_mem_ready;

    // A load in E whose destination feeds D cannot be forwarded in time
    assign load_use = e_valid & e_is_load & (e_rd != REG_X0) &
                      ((d_use_rs1 & (d_rs1 == e_rd)) | (d_use_rs2 & (d_rs2 == e_rd)));

    // New MDU ops only start from IDLE; MDU_DONE still holds the finished op in E
    assign mdu_issue = (state == IDLE) & e_valid & e_mdu_start & ~freeze;
    assign mdu_hold  = (state == MDU_BUSY) & ~mdu_done;

    // Track MDU occupancy; completion seen during a memory freeze is latched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu_issue) begin
                        state <= MDU_BUSY;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_done) begin
                        state <= freeze ? MDU_DONE : IDLE;
                    end
                end
                MDU_DONE: begin
                    if (!freeze) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Priority mux: freeze > MDU stall > taken jump/branch > load-use
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        mdu_go  = 1'b0;
        if (!rst) begin
            if (freeze) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
            end else if (mdu_issue || mdu_hold) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
                mdu_go  = mdu_issue;
            end else if (e_jb) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_f),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_d),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       d_rs1, d_rs2, e_rd;
    logic             d_use_rs1, d_use_rs2;
    logic             e_valid, e_is_load, e_jb, e_mdu_start;
    logic             mdu_done, m_mem_req, m_mem_ready;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_m, mdu_go;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic [7:0]       ctl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: is an MDU op outstanding, and was its completion
    // seen while memory was stalling
    bit m_busy    = 1'b0;
    bit m_latched = 1'b0;
    int m_sc      = 0;
    int m_fc      = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .e_valid(e_valid), .e_rd(e_rd), .e_is_load(e_is_load), .e_jb(e_jb),
        .e_mdu_start(e_mdu_start), .mdu_done(mdu_done),
        .m_mem_req(m_mem_req), .m_mem_ready(m_mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .mdu_go(mdu_go),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Monitor: compare every presented cycle against the oldest expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin : mon
            exp_t e;
            logic [7:0] act;
            e   = sb_q.pop_front();
            act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, mdu_go};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL ctl t=%0t got %b want %b (sf sd se sm fd fe fm go)", $time, act, e.ctl);
            end
            checks++;
            if (stall_cnt !== e.sc) begin
                errors++;
                $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, stall_cnt, e.sc);
            end
            checks++;
            if (flush_cnt !== e.fc) begin
                errors++;
                $display("FAIL flush_cnt t=%0t got %0d want %0d", $time, flush_cnt, e.fc);
            end
        end
    end

    task automatic clr();
        rst = 1'b0; d_rs1 = 5'd0; d_rs2 = 5'd0; d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
        e_valid = 1'b0; e_rd = 5'd0; e_is_load = 1'b0; e_jb = 1'b0; e_mdu_start = 1'b0;
        mdu_done = 1'b0; m_mem_req = 1'b0; m_mem_ready = 1'b0;
    endtask

    // Predict this cycle's outputs from the current inputs, queue them,
    // advance the model across the coming edge, then move to the next cycle
    task automatic cycle();
        exp_t e;
        bit frz, lu, issue, hold;
        frz   = m_mem_req && !m_mem_ready;
        lu    = e_valid && e_is_load && (e_rd != 5'd0) &&
                ((d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd));
        issue = !m_busy && !m_latched && e_valid && e_mdu_start && !frz;
        hold  = m_busy && !mdu_done;
        e.ctl = 8'b0;
        if (rst) begin
            m_sc = 0; m_fc = 0; m_busy = 1'b0; m_latched = 1'b0;
            e.sc = '0; e.fc = '0;
        end else begin
            if (frz)                e.ctl = 8'b1111_0000;
            else if (issue || hold) e.ctl = {7'b1110_001, issue};
            else if (e_jb)          e.ctl = 8'b0000_1100;
            else if (lu)            e.ctl = 8'b1100_0100;
            e.sc = CNT_W'(m_sc);
            e.fc = CNT_W'(m_fc);
            if (e.ctl[7] && m_sc < CMAX) m_sc++;
            if (e.ctl[3] && m_fc < CMAX) m_fc++;
            if (issue) m_busy = 1'b1;
            else if (m_busy && mdu_done) begin
                m_busy    = 1'b0;
                m_latched = frz;
            end else if (m_latched && !frz) m_latched = 1'b0;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        e_valid = 1'b1; e_is_load = 1'b1; e_rd = rd; d_rs1 = 5'd5; d_use_rs1 = 1'b1;
    endtask

    task automatic mdu_issue_cycle();
        clr(); e_valid = 1'b1; e_mdu_start = 1'b1; cycle();
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle(); cycle();

        // Load-use on x5, then bubble, then same shape against x0
        clr(); set_load_use(5'd5); cycle();
        clr(); cycle();
        clr(); set_load_use(5'd0); cycle();

        // Taken branch, and branch coinciding with load-use
        clr(); e_jb = 1'b1; cycle();
        clr(); set_load_use(5'd5); e_jb = 1'b1; cycle();
        clr(); cycle();

        // MDU latency 4
        mdu_issue_cycle();
        for (int i = 0; i < 3; i++) begin clr(); e_valid = 1'b1; e_mdu_start = 1'b1; cycle(); end
        clr(); e_valid = 1'b1; e_mdu_start = 1'b1; mdu_done = 1'b1; cycle();
        clr(); cycle();

        // Completion during memory freeze, then release with MDU op still in E
        mdu_issue_cycle();
        clr(); e_valid = 1'b1; e_mdu_start = 1'b1; cycle();
        clr(); e_valid = 1'b1; e_mdu_start = 1'b1; mdu_done = 1'b1; m_mem_req = 1'b1; cycle();
        clr(); e_valid = 1'b1; e_mdu_start = 1'b1; m_mem_req = 1'b1; m_mem_ready = 1'b1; cycle();
        clr(); cycle();

        // Reset while MDU busy
        mdu_issue_cycle();
        clr(); e_valid = 1'b1; e_mdu_start = 1'b1; cycle();
        clr(); rst = 1'b1; e_valid = 1'b1; e_mdu_start = 1'b1; cycle();
        clr(); cycle();
        clr(); mdu_done = 1'b1; cycle();

        // Saturation: 20 frozen cycles on a 4-bit counter
        for (int i = 0; i < 20; i++) begin clr(); m_mem_req = 1'b1; cycle(); end
        clr(); cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin : rnd
            bit would_issue;
            clr();
            rst         = ($urandom_range(0, 199) == 0);
            e_valid     = ($urandom_range(0, 9) != 0);
            e_rd        = 5'($urandom_range(0, 3));
            d_rs1       = 5'($urandom_range(0, 3));
            d_rs2       = 5'($urandom_range(0, 3));
            d_use_rs1   = $urandom_range(0, 1);
            d_use_rs2   = $urandom_range(0, 1);
            e_is_load   = ($urandom_range(0, 2) == 0);
            e_jb        = ($urandom_range(0, 7) == 0);
            e_mdu_start = !e_jb && ($urandom_range(0, 6) == 0);
            m_mem_req   = ($urandom_range(0, 2) == 0);
            m_mem_ready = ($urandom_range(0, 1) == 0);
            would_issue = !m_busy && !m_latched && e_valid && e_mdu_start &&
                          !(m_mem_req && !m_mem_ready);
            if (would_issue || m_latched) mdu_done = 1'b0;
            else if (m_busy)              mdu_done = ($urandom_range(0, 2) == 0);
            else                          mdu_done = ($urandom_range(0, 19) == 0);
            cycle();
        end

        clr();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It drives the stall and flush inputs of the F, D, E and M pipeline registers. It resolves load-use hazards, taken jumps/branches resolved in E, multi-cycle MUL/DIV occupancy of E, and data-memory wait states. It also keeps saturating stall/flush performance counters.

## Interface
- CNT_W, 32, width of performance counters
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- d_rs1, d_rs2  in  5  source register indices of the instruction in D
- d_use_rs1, d_use_rs2  in  1  D instruction actually reads rs1/rs2
- e_valid  in  1  E holds a real (non-bubble) instruction
- e_rd  in  5  destination index of the E instruction
- e_is_load  in  1  E instruction is a load
- e_jb  in  1  E instruction is a taken branch/jump (resolved this cycle)
- e_mdu_start  in  1  E instruction is a MUL/DIV op; mutually exclusive with e_jb
- mdu_done  in  1  MDU result valid (one-cycle pulse)
- m_mem_req, m_mem_ready  in  1  data-memory request from M / memory ready
- stall_f, stall_d, stall_e, stall_m  out  1  hold PC / D / E / M register
- flush_d, flush_e, flush_m  out  1  load NOP (32'h0000_0013) into D / E / M register
- mdu_go  out  1  one-cycle start pulse to MDU
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- freeze = m_mem_req & ~m_mem_ready. Highest priority.
  - Forces stall_f/d/e/m = 1.
  - Forces all flush_* = 0 and mdu_go = 0.
- FSM states: IDLE, MDU_BUSY, MDU_DONE.
- IDLE:
  - e_valid & e_mdu_start & ~freeze → mdu_go=1, stall_f/d/e=1, flush_m=1; next MDU_BUSY.
  - Otherwise no MDU action.
- MDU_BUSY:
  - ~mdu_done → stall_f/d/e=1, flush_m=1; stay.
  - mdu_done & ~freeze → MDU stalls released this cycle; next IDLE.
  - mdu_done & freeze → next MDU_DONE, which latches completion.
- MDU_DONE:
  - No MDU stalls; waits for ~freeze, then → IDLE.
  - e_mdu_start is ignored, so there is no re-issue.
- jb flush (not frozen, not MDU-stalled):
  - e_jb=1 → flush_d=1, flush_e=1 for that cycle.
  - stall_f=0, so the PC loads the target.
- Load-use:
  - Hazard = e_valid & e_is_load & e_rd≠0 & ((d_use_rs1 & d_rs1==e_rd) | (d_use_rs2 & d_rs2==e_rd)).
  - Action: stall_f=1, stall_d=1, flush_e=1 for one cycle. The bubble in E clears it.
- Priority: freeze > MDU stall > jb flush > load-use. A jb that coincides with load-use gets a jb flush only.
- Stall/flush outputs are combinational (Mealy) from state and inputs. All are forced 0 while rst=1.
- Counters:
  - stall_cnt +1 on each cycle with stall_f=1.
  - flush_cnt +1 on each cycle with flush_d=1.
  - Both saturate at all-ones and do not wrap.

## Timing
- Reset values: state IDLE; stall_cnt=0, flush_cnt=0; all stall/flush/mdu_go = 0.
- Reset mid-operation (any state): return to IDLE immediately. A pending MDU completion is discarded.
- Load-use costs exactly 1 bubble cycle. jb costs 2 squashed instructions and 0 extra stall cycles.
- MDU op of latency N (mdu_done N cycles after mdu_go, N≥1):
  - E held N+1 cycles total, counting the issue and done cycles.
  - mdu_go asserted exactly once per op.
- mdu_done is never expected in the mdu_go cycle. mdu_done in IDLE is ignored.
- Memory wait: stalls asserted in the same cycle as req & ~ready. They are released in the cycle ready=1.
- A jb or load-use condition present during freeze or an MDU stall is evaluated again on release. It is not lost, because the E/D contents are held.

## Structure
- Package pipe_ctrl_pkg contains:
  - FSM state enum {IDLE, MDU_BUSY, MDU_DONE}
  - NOP_INST = 32'h0000_0013
  - REG_X0 = 5'd0
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output count) is instantiated twice.
- Hazard compare and priority mux stay flat in the top module.

## Test plan
- Load-use: E = load x5, D reads rs1=x5 → cycle 0: stall_f=stall_d=flush_e=1; cycle 1: all 0; stall_cnt=1. Repeat with e_rd=x0 → no stall.
- Branch: e_jb=1 for 1 cycle with no freeze → flush_d=flush_e=1, stall_f=0; flush_cnt=1.
- MDU N=4:
  - e_mdu_start=1, mdu_done 4 cycles after mdu_go → mdu_go once.
  - stall_f/d/e=1 for 5 cycles, including the done cycle? No: released in the done cycle, so stalls are high for 4 cycles. State returns to IDLE; stall_cnt=4.
- Freeze overlap: MDU_BUSY, mdu_done arrives while m_mem_req=1, ready=0 → state MDU_DONE, all 4 stalls held. Ready=1 next cycle → all stalls 0, IDLE, no second mdu_go.
- Reset mid-MDU: assert rst in MDU_BUSY → outputs 0 immediately, counters 0, IDLE after release.
- Saturation: CNT_W=4, stall for 20 cycles → stall_cnt=4'hF, no wrap.
